// File: rtl/aemb2_pipe_sched.sv
// AEMB2 pipeline stall scheduler: pipeline enables, thread phase, bus/FSL waits, IRQ gating.
// Optional bus timeout counter enabled by defining AEMB2_BUS_TMO_EN.
module aemb2_pipe_sched #(
   parameter bit AEMB_HTX = 1'b1,
   parameter int TMO_W    = 8
) (
   input  logic gclk,
   input  logic grst,
   input  logic ich_hit,
   input  logic dwb_req,
   input  logic dwb_ack,
   input  logic fsl_req,
   input  logic fsl_ack,
   input  logic int_req,
   input  logic int_ena,
   input  logic imm_of,
   input  logic bds_of,
   output logic dena,
   output logic iena,
   output logic gpha,
   output logic dwb_stb,
   output logic fsl_stb,
   output logic int_ack,
   output logic bus_err
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      FWAIT = 2'd2,
      IWAIT = 2'd3
   } state_t;

   state_t r_state;
   state_t w_nxt;
   logic   r_gpha;
   logic   r_int_ack;
   logic   w_dack;
   logic   w_fack;
   logic   w_berr;
   logic   w_dena_raw;
   logic   w_dena;
   logic   w_int;

`ifdef AEMB2_BUS_TMO_EN
   logic [TMO_W-1:0] r_cnt;
   logic             w_full;

   // An expired counter stands in for the missing acknowledge.
   assign w_full = &r_cnt;
   assign w_dack = dwb_ack | w_full;
   assign w_fack = fsl_ack | w_full;
   assign w_berr = grst & w_full &
                   ((r_state == DWAIT & ~dwb_ack) |
                    (r_state == FWAIT & ~fsl_ack));

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         r_cnt <= '0;
      end else if ((r_state == DWAIT && !w_dack) ||
                   (r_state == FWAIT && !w_fack)) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end
`else
   assign w_dack = dwb_ack;
   assign w_fack = fsl_ack;
   assign w_berr = (TMO_W < 1);
`endif

   always_comb begin
      w_nxt      = r_state;
      w_dena_raw = 1'b0;
      unique case (r_state)
         RUN: begin
            if (dwb_req) begin
               w_nxt = DWAIT;
            end else if (fsl_req) begin
               w_nxt = FWAIT;
            end else begin
               w_dena_raw = ich_hit;
            end
         end
         DWAIT: begin
            if (w_dack) begin
               w_dena_raw = ich_hit;
               w_nxt      = ich_hit ? RUN : IWAIT;
            end
         end
         FWAIT: begin
            if (w_fack) begin
               w_dena_raw = ich_hit;
               w_nxt      = ich_hit ? RUN : IWAIT;
            end
         end
         IWAIT: begin
            w_dena_raw = ich_hit;
            if (ich_hit) begin
               w_nxt = RUN;
            end
         end
      endcase
   end

   assign w_dena  = grst & w_dena_raw;
   assign dena    = w_dena;
   assign iena    = w_dena;
   assign dwb_stb = grst & (r_state == DWAIT);
   assign fsl_stb = grst & (r_state == FWAIT);
   assign gpha    = r_gpha;
   assign int_ack = r_int_ack;
   assign bus_err = w_berr;

   // Only thread 0 takes interrupts; never inside an IMM pair or delay slot.
   assign w_int = w_dena & int_req & int_ena & ~imm_of & ~bds_of &
                  ~r_int_ack & (~AEMB_HTX | ~r_gpha);

   always_ff @(posedge gclk or negedge grst) begin
      if (!grst) begin
         r_state   <= RUN;
         r_gpha    <= 1'b0;
         r_int_ack <= 1'b0;
      end else begin
         r_state   <= w_nxt;
         r_int_ack <= w_int;
         if (AEMB_HTX && w_dena) begin
            r_gpha <= ~r_gpha;
         end
      end
   end

endmodule

// File: tb/tb_aemb2_pipe_sched.sv
// Self-checking bench for aemb2_pipe_sched: vector table plus hand sequences.
// Expected outputs go through a scoreboard queue; timeout part uses AEMB2_BUS_TMO_EN.
module tb_aemb2_pipe_sched;

   logic gclk;
   logic grst;
   logic ich_hit, dwb_req, dwb_ack, fsl_req, fsl_ack;
   logic int_req, int_ena, imm_of, bds_of;
   logic dena, iena, gpha, dwb_stb, fsl_stb, int_ack, bus_err;

   // in : {ich, dreq, dack, freq, fack, ireq, iena, imm, bds}
   // exp: {dena, iena, gpha, dwb_stb, fsl_stb, int_ack, bus_err}
   typedef struct {
      logic [8:0] in;
      logic [6:0] exp;
   } vec_t;

   vec_t       tbl[32];
   logic [6:0] sb_q[$];
   int         checks = 0;
   int         errors = 0;

   aemb2_pipe_sched #(
      .AEMB_HTX(1'b1),
      .TMO_W   (4)
   ) dut (
      .gclk   (gclk),
      .grst   (grst),
      .ich_hit(ich_hit),
      .dwb_req(dwb_req),
      .dwb_ack(dwb_ack),
      .fsl_req(fsl_req),
      .fsl_ack(fsl_ack),
      .int_req(int_req),
      .int_ena(int_ena),
      .imm_of (imm_of),
      .bds_of (bds_of),
      .dena   (dena),
      .iena   (iena),
      .gpha   (gpha),
      .dwb_stb(dwb_stb),
      .fsl_stb(fsl_stb),
      .int_ack(int_ack),
      .bus_err(bus_err)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   task automatic drive(input logic [8:0] in);
      {ich_hit, dwb_req, dwb_ack, fsl_req, fsl_ack,
       int_req, int_ena, imm_of, bds_of} = in;
   endtask

   task automatic compare(input string nm);
      logic [6:0] got;
      logic [6:0] e;
      got = {dena, iena, gpha, dwb_stb, fsl_stb, int_ack, bus_err};
      e   = sb_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s got=%b exp=%b (dena iena gpha dstb fstb iack berr)",
                  nm, got, e);
      end
   endtask

   task automatic apply(input logic [8:0] in, input logic [6:0] exp,
                        input string nm);
      @(negedge gclk);
      drive(in);
      sb_q.push_back(exp);
      #2;
      compare(nm);
   endtask

   initial begin
      tbl[0]  = '{9'b100000000, 7'b1100000};
      tbl[1]  = '{9'b100000000, 7'b1110000};
      tbl[2]  = '{9'b100000000, 7'b1100000};
      tbl[3]  = '{9'b100000000, 7'b1110000};
      tbl[4]  = '{9'b110000000, 7'b0000000};
      tbl[5]  = '{9'b110000000, 7'b0001000};
      tbl[6]  = '{9'b110000000, 7'b0001000};
      tbl[7]  = '{9'b111000000, 7'b1101000};
      tbl[8]  = '{9'b100000000, 7'b1110000};
      tbl[9]  = '{9'b110000000, 7'b0000000};
      tbl[10] = '{9'b011000000, 7'b0001000};
      tbl[11] = '{9'b000000000, 7'b0000000};
      tbl[12] = '{9'b000000000, 7'b0000000};
      tbl[13] = '{9'b100000000, 7'b1100000};
      tbl[14] = '{9'b100000000, 7'b1110000};
      tbl[15] = '{9'b100100000, 7'b0000000};
      tbl[16] = '{9'b100110000, 7'b1100100};
      tbl[17] = '{9'b110100000, 7'b0010000};
      tbl[18] = '{9'b110110000, 7'b0011000};
      tbl[19] = '{9'b111000000, 7'b1111000};
      tbl[20] = '{9'b100001110, 7'b1100000};
      tbl[21] = '{9'b100001110, 7'b1110000};
      tbl[22] = '{9'b100001100, 7'b1100000};
      tbl[23] = '{9'b100000100, 7'b1110010};
      tbl[24] = '{9'b100000100, 7'b1100000};
      tbl[25] = '{9'b100001101, 7'b1110000};
      tbl[26] = '{9'b100001101, 7'b1100000};
      tbl[27] = '{9'b100001100, 7'b1110000};
      tbl[28] = '{9'b100001000, 7'b1100000};
      tbl[29] = '{9'b100000000, 7'b1110000};
      tbl[30] = '{9'b110001100, 7'b0000000};
      tbl[31] = '{9'b111000000, 7'b1101000};

      grst = 1'b0;
      drive(9'b100000000);
      @(negedge gclk);
      sb_q.push_back(7'b0000000);
      #2;
      compare("reset_gate");

      @(negedge gclk);
      drive(9'b000000000);
      grst = 1'b1;
      #2;
      sb_q.push_back(7'b0000000);
      compare("reset_release");

      for (int i = 0; i < 32; i++) begin
         apply(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
      end

      apply(9'b100100000, 7'b0010000, "fsl_req");
      @(posedge gclk);
      #2;
      sb_q.push_back(7'b0010100);
      compare("fwait");
      #1 grst = 1'b0;
      #1;
      sb_q.push_back(7'b0000000);
      compare("rst_fwait");
      @(negedge gclk);
      drive(9'b100000000);
      @(negedge gclk);
      grst = 1'b1;
      #2;
      sb_q.push_back(7'b1100000);
      compare("rst_release_run");

`ifdef AEMB2_BUS_TMO_EN
      apply(9'b110000000, 7'b0010000, "tmo_req");
      for (int c = 1; c <= 15; c++) begin
         apply(9'b110000000, 7'b0011000, $sformatf("tmo_wait%0d", c));
      end
      apply(9'b110000000, 7'b1111001, "tmo_expire");
      apply(9'b100000000, 7'b1100000, "tmo_run");
`else
      apply(9'b110000000, 7'b0010000, "long_req");
      for (int c = 1; c <= 19; c++) begin
         apply(9'b110000000, 7'b0011000, $sformatf("long_wait%0d", c));
      end
      apply(9'b111000000, 7'b1111000, "long_ack");
      apply(9'b100000000, 7'b1100000, "long_run");
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
